// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared size defaults for the matrix-vector result path
package mm_pkg;
    localparam int MM_DW    = 32;
    localparam int MM_NUM   = 16;
    localparam int MM_DEPTH = 4;
    localparam int ROW_W    = MM_DW * MM_NUM;
endpackage

// File: rtl/mv_result_packer_if.sv
// rtl/mv_result_packer_if.sv - scalar-in / packed-row-out bus of the result packer
interface mv_result_packer_if
    import mm_pkg::*;
#(
    parameter int DW  = MM_DW,
    parameter int NUM = MM_NUM
);
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              flush;
    logic [DW*NUM-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              almost_full;
    logic              overflow;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  out_data, out_valid, almost_full, overflow
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output out_data, out_valid, almost_full, overflow
    );
endinterface

// File: rtl/mv_row_fifo.sv
// rtl/mv_row_fifo.sv - synchronous row FIFO with registered head word and occupancy count
module mv_row_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic          wr_en, rd_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign rd_en   = pop_i && (count_q != '0);
    assign wr_en   = push_i && (!full_o || rd_en);
    assign rd_nxt  = rd_ptr_q + AW'(1);
    assign rdata_o = rdata_q;
    assign count_o = count_q;

    // Head register is loaded with whatever becomes the oldest entry after this edge.
    always_comb begin
        rdata_d = rdata_q;
        count_d = count_q;
        if (rd_en) begin
            if (count_q > (AW+1)'(1))
                rdata_d = mem_q[rd_nxt];
            else
                rdata_d = wr_en ? wdata_i : '0;
        end else if (count_q == '0 && wr_en) begin
            rdata_d = wdata_i;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_nxt;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/mv_result_packer.sv
// rtl/mv_result_packer.sv - packs scalar dot-product results into rows; MV_PACKER_OVF_CNT_EN adds ovf_count
module mv_result_packer
    import mm_pkg::*;
#(
    parameter int DW    = MM_DW,
    parameter int NUM   = MM_NUM,
    parameter int DEPTH = MM_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MV_PACKER_OVF_CNT_EN
    output logic [15:0] ovf_count,
`endif
    mv_result_packer_if.slave bus
);
    localparam int RW = DW * NUM;
    localparam int CW = $clog2(NUM);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] asm_q, asm_d, row_wr;
    logic          overflow_q, overflow_d;
    logic          last_lane, push, pop, full, drop;
    logic [AW:0]   fifo_count;
    logic [RW-1:0] fifo_rdata;

    assign last_lane = (cnt_q == CW'(NUM - 1));

    always_comb begin
        row_wr = asm_q;
        for (int i = 0; i < NUM; i++) begin
            if (bus.in_valid && cnt_q == CW'(i)) row_wr[i*DW +: DW] = bus.in_data;
        end
    end

    // A word arriving with flush is folded into the row before it is closed.
    assign push = !rst && ((bus.in_valid && last_lane) ||
                           (bus.flush && (cnt_q != '0 || bus.in_valid)));
    assign pop  = bus.out_valid && bus.out_ready;
    assign drop = push && full && !pop;

    always_comb begin
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        overflow_d = overflow_q | drop;
        if (push) begin
            cnt_d = '0;
            asm_d = '0;
        end else if (bus.in_valid) begin
            cnt_d = cnt_q + CW'(1);
            asm_d = row_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
        end
    end

    mv_row_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (row_wr),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (full)
    );

    assign bus.out_valid   = !rst && (fifo_count != '0);
    assign bus.out_data    = rst ? '0 : fifo_rdata;
    assign bus.almost_full = !rst && (fifo_count >= (AW+1)'(DEPTH - 1));
    assign bus.overflow    = overflow_q;

`ifdef MV_PACKER_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            ovf_cnt_q <= '0;
        else if (drop && ovf_cnt_q != 16'hFFFF)
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign ovf_count = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_mv_result_packer.sv
// tb/tb_mv_result_packer.sv - directed and random bench for mv_result_packer with a queue-based model
module tb_mv_result_packer;
    import mm_pkg::*;

    localparam int DW    = MM_DW;
    localparam int NUM   = MM_NUM;
    localparam int DEPTH = MM_DEPTH;

    typedef logic [ROW_W-1:0] row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mv_result_packer_if #(.DW(DW), .NUM(NUM)) bus ();
`ifdef MV_PACKER_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    mv_result_packer #(.DW(DW), .NUM(NUM), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MV_PACKER_OVF_CNT_EN
        .ovf_count (ovf_count),
`endif
        .bus       (bus)
    );

    row_t          mq[$];
    logic [DW-1:0] cur[$];
    bit            ovf_m;
    int            drops_m;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(string tag, row_t obs, row_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic row_t pack_cur();
        row_t r = '0;
        foreach (cur[i]) r[i*DW +: DW] = cur[i];
        return r;
    endfunction

    task automatic check_outs(string tag);
        chk({tag, ":valid"}, row_t'(bus.out_valid), row_t'(mq.size() > 0));
        if (mq.size() > 0) chk({tag, ":data"}, bus.out_data, mq[0]);
        chk({tag, ":afull"}, row_t'(bus.almost_full), row_t'((DEPTH - mq.size()) <= 1));
        chk({tag, ":ovf"}, row_t'(bus.overflow), row_t'(ovf_m));
`ifdef MV_PACKER_OVF_CNT_EN
        chk({tag, ":ovfcnt"}, row_t'(ovf_count), row_t'(drops_m > 65535 ? 65535 : drops_m));
`endif
    endtask

    task automatic cyc(string tag, bit v, logic [DW-1:0] d, bit f, bit r);
        bit   pop, push, was_full;
        row_t row;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
        pop      = (mq.size() > 0) && r;
        was_full = (mq.size() == DEPTH);
        if (v) cur.push_back(d);
        push = (v && cur.size() == NUM) || (f && cur.size() > 0);
        row  = pack_cur();
        if (push) cur.delete();
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (!was_full || pop) mq.push_back(row);
            else begin
                ovf_m = 1'b1;
                drops_m++;
            end
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = $urandom;
            bus.flush     = 1'b0;
            bus.out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst:valid", row_t'(bus.out_valid), '0);
            chk("rst:afull", row_t'(bus.almost_full), '0);
            chk("rst:data", bus.out_data, '0);
            chk("rst:ovf", row_t'(bus.overflow), '0);
        end
        mq.delete();
        cur.delete();
        ovf_m   = 1'b0;
        drops_m = 0;
        rst     = 1'b0;
        cyc("post_rst", 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic full_row(string tag, bit r, logic [DW-1:0] base);
        for (int k = 0; k < NUM; k++) cyc(tag, 1'b1, base + DW'(k), 1'b0, r);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        do_reset(3);

        // Flush with nothing assembled produces no row.
        cyc("flush_empty", 1'b0, '0, 1'b1, 1'b1);
        cyc("flush_empty2", 1'b0, '0, 1'b0, 1'b1);
        chk("flush_empty:valid", row_t'(bus.out_valid), '0);

        // Sixteen words 1..16.
        for (int k = 1; k <= NUM; k++) cyc("row16", 1'b1, DW'(k), 1'b0, 1'b1);
        chk("row16:valid", row_t'(bus.out_valid), row_t'(1));
        chk("row16:lane0", row_t'(bus.out_data[0 +: DW]), row_t'(1));
        chk("row16:lane15", row_t'(bus.out_data[15*DW +: DW]), row_t'(16));
        cyc("row16:pop", 1'b0, '0, 1'b0, 1'b1);
        chk("row16:empty", row_t'(bus.out_valid), '0);

        // Partial row closed by flush, then a word coincident with flush.
        for (int k = 0; k < 5; k++) cyc("part", 1'b1, DW'(32'hA + k), 1'b0, 1'b1);
        cyc("part:flush", 1'b0, '0, 1'b1, 1'b1);
        chk("part:lane0", row_t'(bus.out_data[0 +: DW]), row_t'(32'hA));
        chk("part:lane4", row_t'(bus.out_data[4*DW +: DW]), row_t'(32'hE));
        chk("part:upper", row_t'(bus.out_data[ROW_W-1:5*DW]), '0);
        cyc("part:next", 1'b1, DW'(32'h55), 1'b1, 1'b1);
        chk("part:next_lane0", row_t'(bus.out_data[0 +: DW]), row_t'(32'h55));
        chk("part:next_lane1", row_t'(bus.out_data[DW +: DW]), '0);
        cyc("part:drain", 1'b0, '0, 1'b0, 1'b1);

        // Five rows with no downstream acceptance.
        for (int r = 0; r < 5; r++) begin
            full_row("stall", 1'b0, DW'($urandom));
            if (r == 1) chk("stall:afull_r2", row_t'(bus.almost_full), '0);
            if (r == 2) chk("stall:afull_r3", row_t'(bus.almost_full), row_t'(1));
            if (r == 3) chk("stall:ovf_r4", row_t'(bus.overflow), '0);
            if (r == 4) chk("stall:ovf_r5", row_t'(bus.overflow), row_t'(1));
        end
        for (int r = 0; r < DEPTH; r++) cyc("stall:drain", 1'b0, '0, 1'b0, 1'b1);
        chk("stall:empty", row_t'(bus.out_valid), '0);

        // Full FIFO with a pop in the cycle the fifth row completes.
        do_reset(1);
        for (int r = 0; r < 4; r++) full_row("popfull", 1'b0, DW'(r * 32'h100));
        for (int k = 0; k < NUM - 1; k++) cyc("popfull:r5", 1'b1, DW'(32'h900 + k), 1'b0, 1'b0);
        cyc("popfull:last", 1'b1, DW'(32'h9FF), 1'b0, 1'b1);
        chk("popfull:ovf", row_t'(bus.overflow), '0);
        for (int r = 0; r < 4; r++) begin
            chk("popfull:queued", row_t'(bus.out_valid), row_t'(1));
            cyc("popfull:drain", 1'b0, '0, 1'b0, 1'b1);
        end
        chk("popfull:empty", row_t'(bus.out_valid), '0);

        // Reset in the middle of a row.
        for (int k = 0; k < 7; k++) cyc("midrst:pre", 1'b1, DW'(32'hDEAD0 + k), 1'b0, 1'b1);
        do_reset(1);
        full_row("midrst", 1'b1, DW'(32'h100));
        chk("midrst:lane0", row_t'(bus.out_data[0 +: DW]), row_t'(32'h100));
        chk("midrst:lane15", row_t'(bus.out_data[15*DW +: DW]), row_t'(32'h10F));
        chk("midrst:ovf", row_t'(bus.overflow), '0);
        cyc("midrst:pop", 1'b0, '0, 1'b0, 1'b1);
        chk("midrst:single", row_t'(bus.out_valid), '0);

        // Random traffic, first with scarce then with plentiful downstream acceptance.
        do_reset(2);
        for (int i = 0; i < 1200; i++) begin
            cyc("rand", ($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 11) == 0),
                (i < 600) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0));
        end

`ifdef MV_PACKER_OVF_CNT_EN
        do_reset(1);
        for (int r = 0; r < DEPTH + 3; r++) full_row("ovfcnt", 1'b0, DW'($urandom));
        chk("ovfcnt:three", row_t'(ovf_count), row_t'(3));
        do_reset(1);
        chk("ovfcnt:cleared", row_t'(ovf_count), '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mv_result_packer.md
MV_RESULT_PACKER -- requirements
Module: mv_result_packer

Interface
REQ-001 SHALL have parameter DW, default 32, width of one fp32 dot-product result.
REQ-002 SHALL have parameter NUM, default 16, results packed per output row.
REQ-003 SHALL have parameter DEPTH, default 4, row FIFO depth; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_data, input, DW, scalar result from the upstream dot-product stage.
REQ-007 SHALL have port in_valid, input, 1, in_data valid this cycle; no backpressure to upstream.
REQ-008 SHALL have port flush, input, 1, close the current partial row.
REQ-009 SHALL have port out_data, output, DW*NUM, packed row; lane i at bits [(i+1)*DW-1 : i*DW].
REQ-010 SHALL have port out_valid, output, 1, out_data valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the row.
REQ-012 SHALL have port almost_full, output, 1, free FIFO rows <= 1.
REQ-013 SHALL have port overflow, output, 1, sticky flag: a completed row was dropped.

Function
REQ-014 SHALL keep a lane counter 0..NUM-1; each in_valid writes in_data into lane[counter] of the assembly register, then increments the counter.
REQ-015 SHALL, on in_valid with counter == NUM-1, push the completed row into the FIFO and wrap the counter to 0 in the same cycle.
REQ-016 SHALL, on flush with counter > 0, push the partial row with unwritten lanes zero, then clear the counter.
REQ-017 SHALL, on flush with counter == 0 and no in_valid, do nothing.
REQ-018 SHALL, on flush and in_valid in the same cycle, include the word first, then push the row once.
REQ-019 SHALL zero the assembly register after every push.
REQ-020 SHALL transfer a row when out_valid && out_ready; out_data SHALL hold stable while out_valid && !out_ready.
REQ-021 SHALL present a row pushed at cycle N into an empty FIFO with out_valid high at cycle N+1; throughput is one row per cycle.
REQ-022 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle.
REQ-023 SHALL otherwise, on a push while full, drop the new row, keep FIFO contents, set overflow, and still clear the counter.
REQ-024 SHALL drive almost_full combinationally from the registered occupancy count.

Reset
REQ-025 SHALL, while rst is high, clear the counter, the assembly register, FIFO pointers and count, and overflow.
REQ-026 SHALL, while rst is high, hold out_valid=0, almost_full=0 and out_data=0.
REQ-027 SHALL, on reset mid-row, discard the partial row; in_valid during rst SHALL be ignored.

Configuration
REQ-028 SHALL, with MV_PACKER_OVF_CNT_EN defined, add output ovf_count[15:0] counting dropped rows, saturating at 16'hFFFF and cleared by rst.
REQ-029 SHALL, without MV_PACKER_OVF_CNT_EN, omit the ovf_count port and its logic; all other behaviour is identical.

Structure
REQ-030 SHALL take the DW, NUM and DEPTH defaults and a row-width constant ROW_W = DW*NUM from a shared package mm_pkg.
REQ-031 SHALL instantiate exactly one sub-module, mv_row_fifo: synchronous, registered read data, with count output.
REQ-032 SHALL keep the lane counter, the assembly register, flush logic and overflow logic in the top level.

Verification
REQ-033 SHALL verify: 16 consecutive in_valid with data 1..16, out_ready=1 -> one row, lane0=1, lane15=16, out_valid at the cycle after the 16th word.
REQ-034 SHALL verify: 5 words 0xA..0xE, then flush -> row with lanes 0-4 = 0xA..0xE and lanes 5-15 = 0; the next word lands in lane 0.
REQ-035 SHALL verify: out_ready=0 with 5 full rows sent -> almost_full high after row 3, overflow set at row 5, and rows 1-4 drain intact in order.
REQ-036 SHALL verify: FIFO full, out_ready=1 in the cycle row 5 completes -> no overflow; 4 rows remain queued.
REQ-037 SHALL verify: rst pulsed after 7 words, then 16 words -> a single row containing only the post-reset words, overflow=0.
REQ-038 SHALL verify: MV_PACKER_OVF_CNT_EN defined, 3 dropped rows -> ovf_count=3; ovf_count=0 after rst.
